lcd_bus_reader: RTL and testbench

Read-cycle engine for the HD44780-style character LCD. It drives the E/RS/RW bus strobes to read the busy flag and address counter (RS=0) or a data byte (RS=1). It can optionally poll the busy flag until it clears, so the LCD init and write sequencers can wait on real LCD status instead of worst-case fixed delays. It shares the LCD pins with the write-side enable/delay logic. The top level muxes E/RS/RW to this block while `active`=1.

---
 rtl/lcd_bus_reader_if.sv | 27 ++
 rtl/lcd_bus_reader.sv | 143 ++++++++++++++
 tb/tb_lcd_bus_reader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_reader_if.sv
// Bus bundle between the LCD read-cycle engine and its owner:
// the request handshake, the LCD pin strobes and the captured status.
interface lcd_bus_reader_if;
  logic       start;
  logic       rs_sel;
  logic       poll;
  logic [7:0] LCD_DATA_IN;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_DATA_OE;
  logic       active;
  logic       done;
  logic [7:0] data_out;
  logic       busy_flag;
  logic       timeout;

  modport master (
    output start, rs_sel, poll, LCD_DATA_IN,
    input  LCD_E, LCD_RS, LCD_RW, LCD_DATA_OE, active, done, data_out, busy_flag, timeout
  );

  modport slave (
    input  start, rs_sel, poll, LCD_DATA_IN,
    output LCD_E, LCD_RS, LCD_RW, LCD_DATA_OE, active, done, data_out, busy_flag, timeout
  );
endinterface

// File: rtl/lcd_bus_reader.sv
// HD44780 read-cycle engine: strobes E/RS/RW to read the busy/address or data register,
// optionally re-reading until the busy flag clears or the poll limit expires.
module lcd_bus_reader #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EHIGH = 12,
  parameter int unsigned T_ELOW  = 12,
  parameter int unsigned TIMEOUT = 205000
) (
  input logic             CLK,
  input logic             RST_N,
  lcd_bus_reader_if.slave bus
);

  // Zero-length phases are stretched to one clock.
  localparam int unsigned TSet = (T_SETUP == 0) ? 1 : T_SETUP;
  localparam int unsigned TEh  = (T_EHIGH == 0) ? 1 : T_EHIGH;
  localparam int unsigned TEl  = (T_ELOW == 0) ? 1 : T_ELOW;

  localparam logic [22:0] SetupLast  = 23'(TSet - 1);
  localparam logic [22:0] EhighLast  = 23'(TEh - 1);
  localparam logic [22:0] ElowLast   = 23'(TEl - 1);
  localparam logic [22:0] TimeoutLim = (TIMEOUT > 32'h7f_ffff) ? 23'h7f_ffff : 23'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StEhigh,
    StElow,
    StDone
  } state_e;

  state_e      state_q;
  logic [22:0] phase_q;
  logic [22:0] elapsed_q;
  logic        poll_en_q;
  logic        e_q;
  logic        rs_q;
  logic        rw_q;
  logic        active_q;
  logic        done_q;
  logic [7:0]  data_q;
  logic        busy_q;
  logic        timeout_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      elapsed_q <= '0;
      poll_en_q <= 1'b0;
      e_q       <= 1'b0;
      rs_q      <= 1'b0;
      rw_q      <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (elapsed_q != '1) begin
        elapsed_q <= elapsed_q + 23'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            rs_q      <= bus.rs_sel;
            rw_q      <= 1'b1;
            active_q  <= 1'b1;
            poll_en_q <= bus.poll & ~bus.rs_sel;
            elapsed_q <= '0;
            timeout_q <= 1'b0;
            phase_q   <= '0;
            state_q   <= StSetup;
          end
        end

        StSetup: begin
          if (phase_q == SetupLast) begin
            phase_q <= '0;
            e_q     <= 1'b1;
            state_q <= StEhigh;
          end else begin
            phase_q <= phase_q + 23'd1;
          end
        end

        StEhigh: begin
          if (phase_q == EhighLast) begin
            phase_q <= '0;
            e_q     <= 1'b0;
            data_q  <= bus.LCD_DATA_IN;
            busy_q  <= rs_q ? 1'b0 : bus.LCD_DATA_IN[7];
            state_q <= StElow;
          end else begin
            phase_q <= phase_q + 23'd1;
          end
        end

        StElow: begin
          if (phase_q == ElowLast) begin
            phase_q <= '0;
            // The limit is only consulted here, so a poll always completes whole reads.
            if (poll_en_q && busy_q && (elapsed_q < TimeoutLim)) begin
              state_q <= StSetup;
            end else begin
              if (poll_en_q && busy_q) begin
                timeout_q <= 1'b1;
              end
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end else begin
            phase_q <= phase_q + 23'd1;
          end
        end

        StDone: begin
          done_q   <= 1'b0;
          rw_q     <= 1'b0;
          rs_q     <= 1'b0;
          active_q <= 1'b0;
          state_q  <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.LCD_E       = e_q;
  assign bus.LCD_RS      = rs_q;
  assign bus.LCD_RW      = rw_q;
  assign bus.LCD_DATA_OE = 1'b0;
  assign bus.active      = active_q;
  assign bus.done        = done_q;
  assign bus.data_out    = data_q;
  assign bus.busy_flag   = busy_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed and randomized read/poll transactions checked cycle by cycle against
// an arithmetic model of the read-cycle timing.
module tb_lcd_bus_reader;

  localparam int unsigned TSet      = 2;
  localparam int unsigned TEh       = 12;
  localparam int unsigned TEl       = 12;
  localparam int unsigned P         = TSet + TEh + TEl;
  localparam int unsigned TFall     = TSet + TEh;
  localparam int unsigned TimeoutTb = 100;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  lcd_bus_reader_if bus ();

  lcd_bus_reader #(
    .T_SETUP(TSet),
    .T_EHIGH(TEh),
    .T_ELOW (TEl),
    .TIMEOUT(TimeoutTb)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  logic [7:0]  seq [8];
  int unsigned seq_len;
  logic [7:0]  prev_data;
  logic        prev_busy;

  // Byte the LCD returns on read i; the last entry repeats forever.
  function automatic logic [7:0] byte_at(input int unsigned i);
    return seq[(i < seq_len) ? i : seq_len - 1];
  endfunction

  function automatic logic [15:0] obs_vec();
    return {bus.LCD_E, bus.LCD_RS, bus.LCD_RW, bus.LCD_DATA_OE, bus.active, bus.done,
            bus.timeout, bus.busy_flag, bus.data_out};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_chk++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge; the request is accepted at the next posedge (edge k).
  task automatic run_read(input logic rs, input logic pl, input bit extra_start);
    int unsigned n;
    int unsigned c;
    logic        pen;
    logic        to;
    logic        act;
    logic        e_exp;
    logic        eb;
    logic [7:0]  ed;
    logic [7:0]  b;
    logic [15:0] exp_v;

    pen = pl & ~rs;
    n   = 1;
    if (pen) begin
      b = byte_at(0);
      while (b[7] && (P * n < TimeoutTb)) begin
        n++;
        b = byte_at(n - 1);
      end
    end
    b  = byte_at(n - 1);
    to = pen & b[7];

    bus.start       = 1'b1;
    bus.rs_sel      = rs;
    bus.poll        = pl;
    bus.LCD_DATA_IN = 8'($urandom);

    for (int unsigned m = 0; m <= P * n + 1; m++) begin
      @(negedge CLK);
      c = (m >= TFall) ? (m - TFall) / P + 1 : 0;
      if (c > n) c = n;
      if (c > 0) begin
        b  = byte_at(c - 1);
        ed = b;
        eb = rs ? 1'b0 : b[7];
      end else begin
        ed = prev_data;
        eb = prev_busy;
      end
      act   = (m <= P * n);
      e_exp = (m < P * n) && ((m % P) >= TSet) && ((m % P) < TFall);
      exp_v = {e_exp, rs & act, act, 1'b0, act, (m == P * n),
               (m >= P * n) ? to : 1'b0, eb, ed};
      chk("bus", obs_vec(), exp_v);

      bus.start  = extra_start && (m == 4);
      bus.rs_sel = 1'($urandom);
      bus.poll   = 1'($urandom);
      if (((m + 1) % P) == TFall) bus.LCD_DATA_IN = byte_at((m + 1) / P);
      else                        bus.LCD_DATA_IN = 8'($urandom);
    end
    bus.start = 1'b0;
    b         = byte_at(n - 1);
    prev_data = b;
    prev_busy = rs ? 1'b0 : b[7];
  endtask

  initial begin
    int unsigned nb;
    bus.start       = 1'b0;
    bus.rs_sel      = 1'b0;
    bus.poll        = 1'b0;
    bus.LCD_DATA_IN = 8'h00;
    prev_data       = 8'h00;
    prev_busy       = 1'b0;

    repeat (3) @(negedge CLK);
    chk("reset", obs_vec(), 16'h0000);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("idle_after_reset", obs_vec(), 16'h0000);

    // Single busy read
    seq[0] = 8'h35; seq_len = 1;
    run_read(1'b0, 1'b0, 1'b0);

    // Poll clears on the fourth read
    seq[0] = 8'h80; seq[1] = 8'h80; seq[2] = 8'h80; seq[3] = 8'h07; seq_len = 4;
    run_read(1'b0, 1'b1, 1'b0);

    // Poll hits the limit
    seq[0] = 8'hFF; seq_len = 1;
    run_read(1'b0, 1'b1, 1'b0);

    // Data read ignores poll
    seq[0] = 8'h80; seq_len = 1;
    run_read(1'b1, 1'b1, 1'b0);

    // Second start mid-read is ignored
    seq[0] = 8'h42; seq_len = 1;
    run_read(1'b0, 1'b0, 1'b1);

    // Reset during E high abandons the read
    bus.start  = 1'b1;
    bus.rs_sel = 1'b1;
    bus.poll   = 1'b0;
    @(negedge CLK);
    bus.start = 1'b0;
    repeat (8) @(negedge CLK);
    chk("pre_abort_e", {15'h0, bus.LCD_E}, 16'h0001);
    #2 RST_N = 1'b0;
    #1 chk("abort", obs_vec(), 16'h0000);
    repeat (3) begin
      @(negedge CLK);
      chk("abort_hold", obs_vec(), 16'h0000);
    end
    RST_N = 1'b1;
    repeat (30) begin
      @(negedge CLK);
      chk("post_abort_idle", obs_vec(), 16'h0000);
    end
    prev_data = 8'h00;
    prev_busy = 1'b0;

    seq[0] = 8'h3C; seq_len = 1;
    run_read(1'b0, 1'b0, 1'b0);

    // Randomized requests: a run of busy reads followed by a ready read
    for (int t = 0; t < 10; t++) begin
      nb = $urandom_range(0, 5);
      for (int unsigned i = 0; i < nb; i++) seq[i] = 8'h80 | 8'($urandom);
      seq[nb] = 8'h7F & 8'($urandom);
      seq_len = nb + 1;
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      run_read(1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
